// File: rtl/score_write_arbiter.sv
// score_write_arbiter
// Merges pad hit/miss events into a signed pending score delta and injects
// it into the CPU register-file write port at the score register index.
// An injection borrows a free write slot (or a forced one once the CPU has
// been starved long enough), then waits one settle cycle so the register
// file read of the score reflects the write before the next injection.

module score_write_arbiter #(
  parameter int NUM_PADS     = 4,
  parameter int SCORE_REG    = 30,
  parameter int WIN_SCORE    = 12,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_PADS-1:0] hit_req,
  input  logic [NUM_PADS-1:0] miss_req,
  input  logic                clear,
  input  logic                cpu_we,
  input  logic [4:0]          cpu_rd,
  input  logic [31:0]         cpu_wdata,
  input  logic [31:0]         score_cur,
  output logic                rf_we,
  output logic [4:0]          rf_rd,
  output logic [31:0]         rf_wdata,
  output logic                cpu_stall,
  output logic signed [7:0]   pending,
  output logic                game_over
);

  localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);
  localparam logic [4:0]       SCORE_IDX = 5'(SCORE_REG);
  localparam logic [31:0]      WIN_C     = 32'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Number of set bits in a pad request vector.
  function automatic logic [7:0] popcount(input logic [NUM_PADS-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < NUM_PADS; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

  // Saturate an 11-bit signed value into the 8-bit signed pending range.
  function automatic logic [7:0] sat8(input logic signed [10:0] v);
    logic [7:0] r;
    if (v > 11'sd127) begin
      r = 8'h7F;
    end else if (v < -11'sd128) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  // Signed score plus signed delta, bounded to 0..32'h7FFF_FFFF.
  function automatic logic [31:0] clamp_score(input logic [31:0] cur,
                                              input logic [7:0]  pend);
    logic signed [32:0] s;
    logic [31:0]        r;
    s = $signed({cur[31], cur}) + $signed({{25{pend[7]}}, pend});
    if (s < 33'sd0) begin
      r = 32'd0;
    end else if (s > 33'sh0_7FFF_FFFF) begin
      r = 32'h7FFF_FFFF;
    end else begin
      r = s[31:0];
    end
    return r;
  endfunction

  state_t             state_r;
  state_t             state_s;
  state_t             next_state_s;
  logic [7:0]         pending_r;
  logic [CNT_W-1:0]   wait_r;
  logic [CNT_W-1:0]   wait_inc_s;
  logic               cpu_stall_r;
  logic               game_over_r;
  logic               inject_cond_s;
  logic               inject_s;
  logic               waiting_s;
  logic signed [9:0]  delta_s;
  logic signed [10:0] delta_ext_s;
  logic signed [10:0] sum_s;

  // A pending delta may take the write port when the CPU is not writing or is frozen.
  always_comb begin
    inject_cond_s = (state_r == IDLE) && !clear && (pending_r != 8'd0) &&
                    (!cpu_we || cpu_stall_r);
  end

  // Effective state of this cycle: IDLE becomes INJECT combinationally.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (inject_cond_s) begin
          state_s = INJECT;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE:  state_s = SETTLE;
      default: state_s = IDLE;
    endcase
  end

  // Next-state logic: one settle cycle after every injection, clear forces IDLE.
  always_comb begin
    next_state_s = IDLE;
    if (clear) begin
      next_state_s = IDLE;
    end else begin
      case (state_s)
        INJECT:  next_state_s = SETTLE;
        SETTLE:  next_state_s = IDLE;
        IDLE:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Per-cycle event delta; events are dropped on clear and after game over.
  always_comb begin
    inject_s    = (state_s == INJECT);
    delta_s     = 10'sd0;
    if (clear || game_over_r) begin
      delta_s = 10'sd0;
    end else begin
      delta_s = $signed({2'b00, popcount(hit_req)}) -
                $signed({2'b00, popcount(miss_req)});
    end
    delta_ext_s = {delta_s[9], delta_s};
    sum_s       = {{3{pending_r[7]}}, pending_r} + delta_ext_s;
    waiting_s   = (state_r == IDLE) && !clear && (pending_r != 8'd0) &&
                  cpu_we && !cpu_stall_r;
    wait_inc_s  = (wait_r == LIMIT_C) ? wait_r : wait_r + CNT_W'(1);
  end

  // Pending accumulator: the injected amount leaves, this cycle's delta stays.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= 8'd0;
    end else if (clear) begin
      pending_r <= 8'd0;
    end else if (inject_s) begin
      pending_r <= sat8(delta_ext_s);
    end else begin
      pending_r <= sat8(sum_s);
    end
  end

  // Starvation counter and CPU freeze request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_r      <= '0;
      cpu_stall_r <= 1'b0;
    end else if (clear || inject_s) begin
      wait_r      <= '0;
      cpu_stall_r <= 1'b0;
    end else if (waiting_s) begin
      wait_r      <= wait_inc_s;
      cpu_stall_r <= cpu_stall_r | (wait_inc_s == LIMIT_C);
    end else if (cpu_stall_r && (state_r == IDLE) && (pending_r == 8'd0)) begin
      // Events cancelled the delta while frozen: nothing left to inject, release the CPU.
      wait_r      <= '0;
      cpu_stall_r <= 1'b0;
    end else begin
      wait_r      <= wait_r;
      cpu_stall_r <= cpu_stall_r;
    end
  end

  // Sticky win flag from the register-file score.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      game_over_r <= 1'b0;
    end else if (clear) begin
      game_over_r <= 1'b0;
    end else if (score_cur >= WIN_C) begin
      game_over_r <= 1'b1;
    end else begin
      game_over_r <= game_over_r;
    end
  end

  // Write-port mux: injection overrides (and discards) the CPU write.
  always_comb begin
    rf_we    = cpu_we;
    rf_rd    = cpu_rd;
    rf_wdata = cpu_wdata;
    if (inject_s) begin
      rf_we    = 1'b1;
      rf_rd    = SCORE_IDX;
      rf_wdata = clamp_score(score_cur, pending_r);
    end else begin
      rf_we    = cpu_we;
      rf_rd    = cpu_rd;
      rf_wdata = cpu_wdata;
    end
  end

  assign cpu_stall = cpu_stall_r;
  assign pending   = pending_r;
  assign game_over = game_over_r;

endmodule

// File: tb/tb_score_write_arbiter.sv
// Scoreboard bench for score_write_arbiter: stimulus pushes every expected
// register-file write, a monitor pops and compares whenever rf_we is high.

module tb_score_write_arbiter;

  logic              clk;
  logic              reset_n;
  logic [3:0]        hit_req;
  logic [3:0]        miss_req;
  logic              clear;
  logic              cpu_we;
  logic [4:0]        cpu_rd;
  logic [31:0]       cpu_wdata;
  logic [31:0]       score_cur;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [31:0]       rf_wdata;
  logic              cpu_stall;
  logic signed [7:0] pending;
  logic              game_over;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  score_write_arbiter #(
    .NUM_PADS(4), .SCORE_REG(30), .WIN_SCORE(12), .STARVE_LIMIT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hit_req(hit_req), .miss_req(miss_req),
    .clear(clear), .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
    .score_cur(score_cur), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .cpu_stall(cpu_stall), .pending(pending), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every register-file write must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: unexpected write rd=%0d data=%h", rf_rd, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_rd, rf_wdata} !== e) begin
          errors++;
          $display("FAIL rf_write: got rd=%0d data=%h expected rd=%0d data=%h",
                   rf_rd, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; hit_req = 4'd0; miss_req = 4'd0; clear = 1'b0;
    cpu_we = 1'b0; cpu_rd = 5'd0; cpu_wdata = 32'd0; score_cur = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pending", {24'd0, pending}, 32'd0);
    check("reset_stall", {31'd0, cpu_stall}, 32'd0);
    check("reset_game_over", {31'd0, game_over}, 32'd0);
    check("reset_rf_we", {31'd0, rf_we}, 32'd0);
    #3 reset_n = 1'b1;
    tick();

    // Two hits, CPU idle: inject 5+2 next cycle, then settle.
    score_cur = 32'd5; hit_req = 4'b0011;
    tick();
    hit_req = 4'd0;
    check("hit2_pending", {24'd0, pending}, 32'd2);
    expect_write(5'd30, 32'd7);
    tick();
    check("hit2_settle_pending", {24'd0, pending}, 32'd0);
    tick();

    // CPU pass-through with nothing pending.
    cpu_we = 1'b1; cpu_rd = 5'd3; cpu_wdata = 32'h0000_ABCD;
    expect_write(5'd3, 32'h0000_ABCD);
    tick();
    cpu_we = 1'b0;

    // Three misses from score 1 clamp to zero.
    score_cur = 32'd1; miss_req = 4'b1110;
    tick();
    miss_req = 4'd0;
    check("miss3_pending", {24'd0, pending}, 32'h0000_00FD);
    expect_write(5'd30, 32'd0);
    tick();
    check("miss3_after_pending", {24'd0, pending}, 32'd0);
    tick();

    // Two pending plus a hit in the injection cycle.
    score_cur = 32'd10; hit_req = 4'b0011; cpu_we = 1'b1; cpu_rd = 5'd5; cpu_wdata = 32'h55;
    expect_write(5'd5, 32'h55);
    tick();
    cpu_we = 1'b0; hit_req = 4'b0001;
    check("two_pending", {24'd0, pending}, 32'd2);
    expect_write(5'd30, 32'd12);
    tick();
    hit_req = 4'd0;
    check("leftover_pending", {24'd0, pending}, 32'd1);
    check("settle_no_write", {31'd0, rf_we}, 32'd0);
    tick();
    expect_write(5'd30, 32'd11);
    tick();
    check("second_inject_pending", {24'd0, pending}, 32'd0);
    tick();

    // Starvation: CPU keeps writing, stall after 64 waiting cycles.
    score_cur = 32'd3; cpu_we = 1'b1; cpu_rd = 5'd7; cpu_wdata = 32'h1234; hit_req = 4'b0001;
    expect_write(5'd7, 32'h1234);
    tick();
    hit_req = 4'd0;
    for (int i = 1; i <= 64; i++) begin
      expect_write(5'd7, 32'h1234);
      if (i == 64) check("stall_before_limit", {31'd0, cpu_stall}, 32'd0);
      tick();
    end
    check("stall_at_limit", {31'd0, cpu_stall}, 32'd1);
    check("stall_pending", {24'd0, pending}, 32'd1);
    expect_write(5'd30, 32'd4);
    tick();
    check("stall_released", {31'd0, cpu_stall}, 32'd0);
    check("stall_after_pending", {24'd0, pending}, 32'd0);
    expect_write(5'd7, 32'h1234);
    tick();
    cpu_we = 1'b0;
    tick();

    // Saturation at +127, then injection clamped at the top.
    score_cur = 32'd0; cpu_we = 1'b1; cpu_rd = 5'd9; cpu_wdata = 32'h99; hit_req = 4'b1111;
    for (int i = 0; i < 33; i++) begin
      expect_write(5'd9, 32'h99);
      tick();
    end
    hit_req = 4'd0;
    check("sat_pending", {24'd0, pending}, 32'h0000_007F);
    cpu_we = 1'b0; score_cur = 32'h7FFF_FFF0;
    expect_write(5'd30, 32'h7FFF_FFFF);
    tick();
    score_cur = 32'd0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_game_over_a", {31'd0, game_over}, 32'd0);

    // Win score: game over next cycle, events ignored, clear restarts.
    score_cur = 32'd12;
    check("no_game_over_yet", {31'd0, game_over}, 32'd0);
    tick();
    check("game_over_set", {31'd0, game_over}, 32'd1);
    score_cur = 32'd0; hit_req = 4'b1111;
    tick();
    hit_req = 4'd0;
    check("game_over_ignores_hits", {24'd0, pending}, 32'd0);
    check("game_over_sticky", {31'd0, game_over}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_game_over", {31'd0, game_over}, 32'd0);

    // Clear drops pending, ignores its own events, CPU write still passes.
    cpu_we = 1'b1; cpu_rd = 5'd2; cpu_wdata = 32'd9; hit_req = 4'b0111;
    expect_write(5'd2, 32'd9);
    tick();
    check("pre_clear_pending", {24'd0, pending}, 32'd3);
    clear = 1'b1; hit_req = 4'b0001;
    expect_write(5'd2, 32'd9);
    tick();
    clear = 1'b0; hit_req = 4'd0; cpu_we = 1'b0;
    check("clear_pending", {24'd0, pending}, 32'd0);
    tick();

    // Reset in the middle of an injection cycle.
    hit_req = 4'b0111;
    tick();
    hit_req = 4'd0;
    check("pre_reset_pending", {24'd0, pending}, 32'd3);
    check("pre_reset_inject", {31'd0, rf_we}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("reset_abort_rf_we", {31'd0, rf_we}, 32'd0);
    check("reset_abort_pending", {24'd0, pending}, 32'd0);
    #5 reset_n = 1'b1;
    tick();
    check("post_reset_pending", {24'd0, pending}, 32'd0);
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover writes expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_write_arbiter.md
SCORE_WRITE_ARBITER -- requirements
Module: score_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_PADS, default 4, number of pad requesters.
REQ-002 SHALL have parameter SCORE_REG, default 30, register-file index holding the score.
REQ-003 SHALL have parameter WIN_SCORE, default 12, score at which the game ends.
REQ-004 SHALL have parameter STARVE_LIMIT, default 64, number of waiting cycles before the CPU is stalled.
REQ-005 SHALL have port clk  input  1  single clock for all state.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port hit_req  input  NUM_PADS  one-cycle pulse per pad hit, +1 each.
REQ-008 SHALL have port miss_req  input  NUM_PADS  one-cycle pulse per pad timeout, -1 each.
REQ-009 SHALL have port clear  input  1  synchronous game-restart pulse.
REQ-010 SHALL have port cpu_we  input  1  CPU register-file write enable.
REQ-011 SHALL have port cpu_rd  input  5  CPU write register index.
REQ-012 SHALL have port cpu_wdata  input  32  CPU write data.
REQ-013 SHALL have port score_cur  input  32  current SCORE_REG contents, read from the register file.
REQ-014 SHALL have port rf_we  output  1  write enable to the register file.
REQ-015 SHALL have port rf_rd  output  5  write index to the register file.
REQ-016 SHALL have port rf_wdata  output  32  write data to the register file.
REQ-017 SHALL have port cpu_stall  output  1  freeze request to the CPU.
REQ-018 SHALL have port pending  output  8  signed accumulated, not-yet-written score delta.
REQ-019 SHALL have port game_over  output  1  sticky flag, set when the win score is reached.

Function
REQ-020 SHALL compute the per-cycle delta as popcount(hit_req) - popcount(miss_req).
REQ-021 SHALL add the delta into pending each cycle, saturating at -128 and +127.
REQ-022 SHALL implement FSM states IDLE, INJECT and SETTLE.
REQ-023 IDLE SHALL go to INJECT in the same cycle when pending != 0 and (cpu_we == 0 or cpu_stall == 1); the injection is combinational in that cycle.
REQ-024 In the injection cycle, rf_we SHALL be 1, rf_rd SHALL be SCORE_REG, and rf_wdata SHALL be clamp(score_cur + sign-extended pending).
REQ-025 The clamp SHALL treat score_cur as signed and bound the result to 0..32'h7FFF_FFFF.
REQ-026 In every non-injection cycle, rf_we, rf_rd and rf_wdata SHALL pass cpu_we, cpu_rd and cpu_wdata through unchanged.
REQ-027 After an injection, pending SHALL become the delta of that same cycle only, because the injected amount is subtracted; no event is lost.
REQ-028 The FSM SHALL spend exactly 1 cycle in SETTLE, with no injection, so score_cur updates before the next read; it then returns to IDLE.
REQ-029 A wait counter SHALL increment each IDLE cycle with pending != 0 and cpu_we == 1, and clear on any injection.
REQ-030 cpu_stall SHALL be registered; it asserts when the wait counter reaches STARVE_LIMIT and deasserts in the cycle after the injection.
REQ-031 While cpu_stall == 1, a CPU write in the injection cycle SHALL be discarded; the CPU holds that write until cpu_stall deasserts.
REQ-032 A CPU write to SCORE_REG that is passed through SHALL leave pending unchanged; pending is then applied on top of the new value.
REQ-033 game_over SHALL be registered and set when score_cur >= WIN_SCORE (unsigned); it stays set until clear or reset.
REQ-034 While game_over == 1, hit_req and miss_req SHALL be ignored; a pending value that is already non-zero still injects.
REQ-035 clear SHALL in one cycle zero pending, the wait counter, cpu_stall and game_over, and force IDLE.
REQ-036 On a clear cycle, events in that cycle SHALL be ignored and no injection SHALL occur; CPU writes pass through.

Reset
REQ-037 reset_n = 0 SHALL asynchronously set: state IDLE, pending 0, wait counter 0, cpu_stall 0, game_over 0.
REQ-038 During reset, rf_* SHALL pass the CPU signals through.
REQ-039 Reset asserted mid-injection SHALL abort the injection immediately; the accumulated pending is discarded.
REQ-040 Release of reset_n SHALL take effect on the first clk edge after deassertion.

Verification
REQ-041 score_cur = 5, hit_req = 4'b0011 for 1 cycle, cpu_we = 0 -> the next cycle drives rf_we = 1, rf_rd = 30, rf_wdata = 7; then 1 SETTLE cycle; pending = 0.
REQ-042 score_cur = 1, miss_req = 4'b1110, cpu_we = 0 -> rf_wdata = 0 (clamped) and pending returns to 0.
REQ-043 cpu_we held 1, one hit pending -> cpu_stall rises after 64 waiting cycles; the next cycle injects score_cur + 1, cpu_wdata is discarded, and cpu_stall falls the cycle after.
REQ-044 A hit in the injection cycle plus 2 pending -> the written value is +2 and pending = +1 afterwards, followed by a second injection after SETTLE.
REQ-045 score_cur reaches 12 -> game_over = 1 the next cycle; later hits leave pending unchanged; a clear pulse zeroes game_over and pending.
REQ-046 reset_n pulled low during an injection cycle with pending = 3 -> rf_we immediately equals cpu_we, and pending = 0 after release.
